branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  - Sequences the EX-stage branch comparator for the always-taken fetch policy.
//  - Captures one conditional branch, drives comparator operands and BrUn, then evaluates the funct3 condition.
//  - On a not-taken outcome (mispredict), issues a flush and a redirect to pc+4 via a valid/ready handshake with fetch.
// PARAMETERS
//  - Width  32  data/PC width
//  - CNT_W  32  perf counter width (BRSTAT_EN only)
// PORTS
//  - clk_i            in   1      clock, rising edge
//  - rst_ni           in   1      reset, asynchronous, active-low
//  - br_valid_i       in   1      branch request from decode/EX
//  - br_ready_o       out  1      controller can accept a branch
//  - br_funct3_i      in   3      B-type funct3
//  - br_pc_i          in   Width  PC of the branch
//  - br_rs1_i         in   Width  operand A
//  - br_rs2_i         in   Width  operand B
//  - kill_i           in   1      pipeline kill (exception/trap), highest priority
//  - cmp_a_o          out  Width  to comparator DataA
//  - cmp_b_o          out  Width  to comparator DataB
//  - cmp_brun_o       out  1      to comparator BrUn
//  - cmp_lt_i         in   1      comparator BrLt
//  - cmp_eq_i         in   1      comparator BrEq
//  - res_valid_o      out  1      one-cycle pulse: branch resolved
//  - res_taken_o      out  1      resolved outcome, valid with res_valid_o
//  - res_mispred_o    out  1      outcome != predicted-taken
//  - illegal_o        out  1      one-cycle pulse: funct3 in {010,011}
//  - flush_o          out  1      one-cycle pulse: kill younger instructions
//  - redirect_valid_o out  1      redirect request to fetch
//  - redirect_ready_i in   1      fetch accepts redirect
//  - redirect_pc_o    out  Width  redirect target = pc+4
// BEHAVIOUR
//  - Reset: FSM=IDLE; all operand/PC regs 0; all outputs 0 except br_ready_o=1.
//  - FSM IDLE: br_ready_o=1.
//    - On br_valid_i&&br_ready_o: register funct3, pc, rs1, rs2; go to EVAL.
//  - cmp_a_o/cmp_b_o always driven from the registers; cmp_brun_o=funct3[1] (BLTU/BGEU).
//  - EVAL: br_ready_o=0; combinational taken:
//    - 000 eq; 001 !eq; 100/110 lt; 101/111 !lt.
//    - funct3 010/011: illegal_o=1, no res_valid_o; go to IDLE.
//    - taken: res_valid_o=1, res_taken_o=1, res_mispred_o=0; go to IDLE.
//    - not taken: res_valid_o=1, res_mispred_o=1, flush_o=1; redirect_pc_o<=pc+4 (mod 2^Width); go to REDIR.
//  - REDIR: redirect_valid_o=1, redirect_pc_o held stable until redirect_ready_i; on accept go to IDLE.
//  - Latency: capture->resolve 1 cycle; min 2 cycles/branch; redirect >=1 cycle after EVAL.
//  - kill_i in any state: next state IDLE; suppresses res_valid_o/flush_o/illegal_o that cycle; drops redirect_valid_o; blocks acceptance in IDLE.
//  - redirect_ready_i outside REDIR is ignored; br_valid_i outside IDLE is not accepted (held by upstream).
//  - pc=32'hFFFF_FFFC not taken -> redirect_pc_o=0 (wrap).
//  - Reset asserted mid-operation: immediate return to reset values; pending redirect discarded.
// CONFIGURATION
//  - Macro BRANCH_RESOLVE_STATS_EN.
//    - Defined: adds outputs stat_br_o, stat_mispred_o (CNT_W each).
//    - stat_br_o increments on every res_valid_o; stat_mispred_o on res_mispred_o.
//    - Both wrap at 2^CNT_W; reset to 0; kill-suppressed resolves are not counted.
//  - Not defined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  - Package branch_ctrl_pkg: funct3 constants (BEQ..BGEU); state enum {IDLE,EVAL,REDIR}; PC increment constant 4.
//  - Sub-module branch_cond_eval (combinational): funct3, lt, eq -> taken, illegal.
//  - Comparator instance lives at the EX-stage level and is wired to cmp_* ports.
// TESTING
//  - BEQ rs1=5 rs2=5 pc=0x100 -> EVAL: res_taken_o=1, mispred=0, no flush; IDLE next cycle.
//  - BLT rs1=-1 rs2=1 (cmp_brun_o=0) -> taken; BLTU same operands (cmp_brun_o=1) -> not taken, flush_o, redirect_pc_o=0x104.
//  - Mispredict with redirect_ready_i low 3 cycles -> redirect_valid_o held, pc stable, br_ready_o=0; accept -> IDLE.
//  - funct3=3'b010 -> illegal_o single pulse, no res_valid_o/flush_o; BGE pc=0xFFFFFFFC rs1=0 rs2=1 -> redirect_pc_o=0.
//  - kill_i in EVAL and in REDIR -> no pulses, redirect dropped, IDLE; rst_ni low in REDIR -> all outputs reset at once.
//  - BRANCH_RESOLVE_STATS_EN: 10 branches with 4 mispredicts -> stat_br_o=10, stat_mispred_o=4.

Source files
------------

// File: rtl/branch_ctrl_pkg.sv
// Shared constants for the EX-stage branch resolve controller.
// Holds the B-type funct3 encodings, the controller state enum and the PC step.
package branch_ctrl_pkg;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam int unsigned PC_INC = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational funct3 condition decode: turns comparator flags into taken/illegal.
// Codes 010/011 have no B-type meaning and are reported as illegal.
module branch_cond_eval
  import branch_ctrl_pkg::*;
(
  input  logic [2:0] i_funct3,
  input  logic       i_lt,
  input  logic       i_eq,
  output logic       o_taken,
  output logic       o_illegal
);

  always_comb begin
    o_taken   = 1'b0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_BEQ:           o_taken = i_eq;
      F3_BNE:           o_taken = !i_eq;
      F3_BLT, F3_BLTU:  o_taken = i_lt;
      F3_BGE, F3_BGEU:  o_taken = !i_lt;
      default:          o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve controller for an always-taken fetch policy: capture, evaluate,
// and on a not-taken outcome flush and redirect fetch to pc+4. Optional
// perf counters are enabled with the macro BRANCH_RESOLVE_STATS_EN.
module branch_resolve_ctrl
  import branch_ctrl_pkg::*;
#(
`ifdef BRANCH_RESOLVE_STATS_EN
  parameter int CNT_W = 32,
`endif
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
`ifdef BRANCH_RESOLVE_STATS_EN
  output logic [CNT_W-1:0] stat_br_o,
  output logic [CNT_W-1:0] stat_mispred_o,
`endif
  input  logic             br_valid_i,
  output logic             br_ready_o,
  input  logic [2:0]       br_funct3_i,
  input  logic [Width-1:0] br_pc_i,
  input  logic [Width-1:0] br_rs1_i,
  input  logic [Width-1:0] br_rs2_i,
  input  logic             kill_i,
  output logic [Width-1:0] cmp_a_o,
  output logic [Width-1:0] cmp_b_o,
  output logic             cmp_brun_o,
  input  logic             cmp_lt_i,
  input  logic             cmp_eq_i,
  output logic             res_valid_o,
  output logic             res_taken_o,
  output logic             res_mispred_o,
  output logic             illegal_o,
  output logic             flush_o,
  output logic             redirect_valid_o,
  input  logic             redirect_ready_i,
  output logic [Width-1:0] redirect_pc_o
);

  state_e           r_state;
  state_e           w_state_next;
  logic [2:0]       r_funct3;
  logic [Width-1:0] r_pc;
  logic [Width-1:0] r_rs1;
  logic [Width-1:0] r_rs2;
  logic [Width-1:0] r_redir_pc;
  logic             w_accept;
  logic             w_load_redir;
  logic             w_taken;
  logic             w_illegal;

  branch_cond_eval u_cond (
    .i_funct3  (r_funct3),
    .i_lt      (cmp_lt_i),
    .i_eq      (cmp_eq_i),
    .o_taken   (w_taken),
    .o_illegal (w_illegal)
  );

  assign cmp_a_o       = r_rs1;
  assign cmp_b_o       = r_rs2;
  assign cmp_brun_o    = r_funct3[1];
  assign redirect_pc_o = r_redir_pc;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= IDLE;
      r_funct3   <= '0;
      r_pc       <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_redir_pc <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_funct3 <= br_funct3_i;
        r_pc     <= br_pc_i;
        r_rs1    <= br_rs1_i;
        r_rs2    <= br_rs2_i;
      end
      // Target is latched so it stays stable for the whole redirect handshake
      if (w_load_redir) begin
        r_redir_pc <= r_pc + Width'(PC_INC);
      end
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_accept         = 1'b0;
    w_load_redir     = 1'b0;
    br_ready_o       = 1'b0;
    res_valid_o      = 1'b0;
    res_taken_o      = 1'b0;
    res_mispred_o    = 1'b0;
    illegal_o        = 1'b0;
    flush_o          = 1'b0;
    redirect_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        br_ready_o = !kill_i;
        if (br_valid_i && !kill_i) begin
          w_accept     = 1'b1;
          w_state_next = EVAL;
        end
      end
      EVAL: begin
        w_state_next = IDLE;
        if (!kill_i) begin
          if (w_illegal) begin
            illegal_o = 1'b1;
          end else begin
            res_valid_o   = 1'b1;
            res_taken_o   = w_taken;
            res_mispred_o = !w_taken;
            flush_o       = !w_taken;
            if (!w_taken) begin
              w_load_redir = 1'b1;
              w_state_next = REDIR;
            end
          end
        end
      end
      REDIR: begin
        if (kill_i) begin
          w_state_next = IDLE;
        end else begin
          redirect_valid_o = 1'b1;
          if (redirect_ready_i) begin
            w_state_next = IDLE;
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [CNT_W-1:0] r_stat_br;
  logic [CNT_W-1:0] r_stat_mispred;

  // Resolve pulses are already kill-gated, so suppressed resolves never count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_stat_br      <= '0;
      r_stat_mispred <= '0;
    end else begin
      if (res_valid_o) begin
        r_stat_br <= r_stat_br + 1'b1;
      end
      if (res_mispred_o) begin
        r_stat_mispred <= r_stat_mispred + 1'b1;
      end
    end
  end

  assign stat_br_o      = r_stat_br;
  assign stat_mispred_o = r_stat_mispred;
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: directed corner cases then
// randomized branches checked against a rule-level reference model.
module tb_branch_resolve_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        br_valid_i;
  logic        br_ready_o;
  logic [2:0]  br_funct3_i;
  logic [31:0] br_pc_i;
  logic [31:0] br_rs1_i;
  logic [31:0] br_rs2_i;
  logic        kill_i;
  logic [31:0] cmp_a_o;
  logic [31:0] cmp_b_o;
  logic        cmp_brun_o;
  logic        cmp_lt_i;
  logic        cmp_eq_i;
  logic        res_valid_o;
  logic        res_taken_o;
  logic        res_mispred_o;
  logic        illegal_o;
  logic        flush_o;
  logic        redirect_valid_o;
  logic        redirect_ready_i;
  logic [31:0] redirect_pc_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] stat_br_o;
  logic [31:0] stat_mispred_o;
`endif

  int n_cmp = 0;
  int n_err = 0;
  int m_br  = 0;
  int m_mis = 0;

  always #5 clk_i = ~clk_i;

  branch_resolve_ctrl dut (
    .clk_i            (clk_i),
    .rst_ni           (rst_ni),
`ifdef BRANCH_RESOLVE_STATS_EN
    .stat_br_o        (stat_br_o),
    .stat_mispred_o   (stat_mispred_o),
`endif
    .br_valid_i       (br_valid_i),
    .br_ready_o       (br_ready_o),
    .br_funct3_i      (br_funct3_i),
    .br_pc_i          (br_pc_i),
    .br_rs1_i         (br_rs1_i),
    .br_rs2_i         (br_rs2_i),
    .kill_i           (kill_i),
    .cmp_a_o          (cmp_a_o),
    .cmp_b_o          (cmp_b_o),
    .cmp_brun_o       (cmp_brun_o),
    .cmp_lt_i         (cmp_lt_i),
    .cmp_eq_i         (cmp_eq_i),
    .res_valid_o      (res_valid_o),
    .res_taken_o      (res_taken_o),
    .res_mispred_o    (res_mispred_o),
    .illegal_o        (illegal_o),
    .flush_o          (flush_o),
    .redirect_valid_o (redirect_valid_o),
    .redirect_ready_i (redirect_ready_i),
    .redirect_pc_o    (redirect_pc_o)
  );

  // External EX-stage comparator that the controller sequences
  always_comb begin
    cmp_eq_i = (cmp_a_o == cmp_b_o);
    cmp_lt_i = cmp_brun_o ? (cmp_a_o < cmp_b_o) : ($signed(cmp_a_o) < $signed(cmp_b_o));
  end

  // Reference: branch outcome straight from the ISA rule on the original operands
  function automatic void ref_branch(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                     output bit illegal, output bit taken);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'(a);
    longint ub = longint'(b);
    illegal = 1'b0;
    taken   = 1'b0;
    case (f3)
      3'd0: taken = (ua == ub);
      3'd1: taken = (ua != ub);
      3'd4: taken = (sa < sb);
      3'd5: taken = (sa >= sb);
      3'd6: taken = (ua < ub);
      3'd7: taken = (ua >= ub);
      default: illegal = 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run_branch(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] a,
                            input logic [31:0] b, input int delay);
    bit ill, tk;
    logic [31:0] exp_pc;
    ref_branch(f3, a, b, ill, tk);
    exp_pc = pc + 32'd4;
    @(negedge clk_i);
    br_valid_i = 1'b1; br_funct3_i = f3; br_pc_i = pc; br_rs1_i = a; br_rs2_i = b;
    #1 chk("idle_ready", br_ready_o, 1);
    @(posedge clk_i);
    @(negedge clk_i);
    br_valid_i = 1'b0; br_rs1_i = $urandom; br_rs2_i = $urandom; br_pc_i = $urandom;
    redirect_ready_i = 1'($urandom_range(0, 1));
    #1;
    chk("eval_ready", br_ready_o, 0);
    chk("cmp_a", cmp_a_o, a);
    chk("cmp_b", cmp_b_o, b);
    chk("cmp_brun", cmp_brun_o, f3 == 3'd6 || f3 == 3'd7 || f3 == 3'd2 || f3 == 3'd3);
    chk("illegal", illegal_o, ill);
    chk("res_valid", res_valid_o, !ill);
    chk("res_taken", res_taken_o, !ill && tk);
    chk("res_mispred", res_mispred_o, !ill && !tk);
    chk("flush", flush_o, !ill && !tk);
    chk("eval_redir_valid", redirect_valid_o, 0);
    if (!ill) begin
      m_br++;
      if (!tk) m_mis++;
    end
    @(posedge clk_i);
    if (!ill && !tk) begin
      for (int d = 0; d < delay; d++) begin
        @(negedge clk_i);
        redirect_ready_i = 1'b0;
        #1;
        chk("wait_redir_valid", redirect_valid_o, 1);
        chk("wait_redir_pc", redirect_pc_o, exp_pc);
        chk("wait_ready", br_ready_o, 0);
        chk("wait_no_res", res_valid_o, 0);
        @(posedge clk_i);
      end
      @(negedge clk_i);
      redirect_ready_i = 1'b1;
      #1;
      chk("acc_redir_valid", redirect_valid_o, 1);
      chk("acc_redir_pc", redirect_pc_o, exp_pc);
      @(posedge clk_i);
    end
    @(negedge clk_i);
    redirect_ready_i = 1'b0;
    #1;
    chk("back_idle_ready", br_ready_o, 1);
    chk("back_idle_redir", redirect_valid_o, 0);
    @(posedge clk_i);
    $display("txn f3=%0d pc=%h a=%h b=%h delay=%0d -> illegal=%0b taken=%0b", f3, pc, a, b, delay, ill, tk);
  endtask

  initial begin
    rst_ni = 1'b0; br_valid_i = 1'b0; br_funct3_i = '0; br_pc_i = '0; br_rs1_i = '0; br_rs2_i = '0;
    kill_i = 1'b0; redirect_ready_i = 1'b0;
    #12;
    chk("rst_ready", br_ready_o, 1);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_illegal", illegal_o, 0);
    chk("rst_redir_valid", redirect_valid_o, 0);
    chk("rst_redir_pc", redirect_pc_o, 0);
    chk("rst_cmp_a", cmp_a_o, 0);
    chk("rst_cmp_b", cmp_b_o, 0);
    chk("rst_brun", cmp_brun_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);

    // Directed cases
    run_branch(3'd0, 32'h100, 32'd5, 32'd5, 0);
    run_branch(3'd4, 32'h100, 32'hFFFF_FFFF, 32'd1, 0);
    run_branch(3'd6, 32'h100, 32'hFFFF_FFFF, 32'd1, 0);
    run_branch(3'd1, 32'h180, 32'd7, 32'd7, 3);
    run_branch(3'd2, 32'h200, 32'd1, 32'd2, 0);
    run_branch(3'd3, 32'h204, 32'd1, 32'd1, 0);
    run_branch(3'd5, 32'hFFFF_FFFC, 32'd0, 32'd1, 1);
    run_branch(3'd7, 32'h300, 32'd1, 32'hFFFF_FFFF, 0);

    // kill in IDLE blocks acceptance
    @(negedge clk_i);
    br_valid_i = 1'b1; br_funct3_i = 3'd0; br_rs1_i = 32'd1; br_rs2_i = 32'd2; kill_i = 1'b1;
    #1 chk("kill_idle_ready", br_ready_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    br_valid_i = 1'b0; kill_i = 1'b0;
    #1 chk("kill_idle_stay", br_ready_o, 1);
    chk("kill_idle_no_res", res_valid_o, 0);
    @(posedge clk_i);

    // kill in EVAL suppresses the resolve pulses
    @(negedge clk_i);
    br_valid_i = 1'b1; br_funct3_i = 3'd0; br_pc_i = 32'h400; br_rs1_i = 32'd1; br_rs2_i = 32'd2;
    @(posedge clk_i);
    @(negedge clk_i);
    br_valid_i = 1'b0; kill_i = 1'b1;
    #1 chk("kill_eval_res", res_valid_o, 0);
    chk("kill_eval_flush", flush_o, 0);
    chk("kill_eval_mispred", res_mispred_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b0;
    #1 chk("kill_eval_redir", redirect_valid_o, 0);
    chk("kill_eval_idle", br_ready_o, 1);
    @(posedge clk_i);

    // kill in REDIR drops the redirect
    @(negedge clk_i);
    br_valid_i = 1'b1; br_funct3_i = 3'd1; br_pc_i = 32'h500; br_rs1_i = 32'd3; br_rs2_i = 32'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    br_valid_i = 1'b0;
    #1 chk("kr_flush", flush_o, 1);
    m_br++; m_mis++;
    @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b1;
    #1 chk("kill_redir_valid", redirect_valid_o, 0);
    @(posedge clk_i);
    @(negedge clk_i);
    kill_i = 1'b0;
    #1 chk("kill_redir_idle", br_ready_o, 1);
    chk("kill_redir_gone", redirect_valid_o, 0);
    @(posedge clk_i);

    // Reset asserted while a redirect is pending
    @(negedge clk_i);
    br_valid_i = 1'b1; br_funct3_i = 3'd6; br_pc_i = 32'h600; br_rs1_i = 32'd5; br_rs2_i = 32'd3;
    @(posedge clk_i);
    @(negedge clk_i);
    br_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    #1 chk("pre_rst_redir", redirect_valid_o, 1);
    chk("pre_rst_pc", redirect_pc_o, 32'h604);
    rst_ni = 1'b0;
    #1 chk("mid_rst_redir", redirect_valid_o, 0);
    chk("mid_rst_pc", redirect_pc_o, 0);
    chk("mid_rst_cmp_a", cmp_a_o, 0);
    chk("mid_rst_ready", br_ready_o, 1);
    m_br = 0; m_mis = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);

    // Randomized branches, biased toward equal operands now and then
    for (int i = 0; i < 40; i++) begin
      logic [31:0] a, b;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : 32'($urandom);
      run_branch(3'($urandom_range(0, 7)), {$urandom_range(0, 32'h3FFF_FFFF), 2'b00}, a, b,
                 int'($urandom_range(0, 3)));
    end

`ifdef BRANCH_RESOLVE_STATS_EN
    @(negedge clk_i);
    chk("stat_br", stat_br_o, m_br);
    chk("stat_mispred", stat_mispred_o, m_mis);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
